irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/cpu_pkg.sv | 15 +
 rtl/irq_prio_enc.sv | 24 ++
 rtl/irq_ctrl.sv | 155 +++++++++++++++
 tb/tb_irq_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: interrupt controller defaults and FSM state type.
package cpu_pkg;

    localparam int         N_IRQ_DEF      = 4;
    localparam int         VEC_W_DEF      = 10;
    localparam logic [9:0] VEC_BASE_DEF   = 10'h3F0;
    localparam int         VEC_STRIDE_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        JUMP = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the
// index of the lowest set bit (bit 0 has the highest priority).
module irq_prio_enc #(
    parameter int N_IRQ = 4,
    parameter int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic [N_IRQ-1:0] req,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Vectored interrupt controller: edge-detects request lines, picks the
// highest-priority eligible line at an instruction boundary and drives a
// two-cycle entry sequence (push return address, then jump to the vector).
// Define NESTED_IRQ_EN to let higher-priority lines preempt active handlers;
// by default any active handler blocks every line.
module irq_ctrl
    import cpu_pkg::*;
#(
    parameter int               N_IRQ      = N_IRQ_DEF,
    parameter int               VEC_W      = VEC_W_DEF,
    parameter logic [VEC_W-1:0] VEC_BASE   = VEC_W'(VEC_BASE_DEF),
    parameter int               VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_in,
    input  logic             fetch,
    input  logic             reti,
    output logic             take,
    output logic             push,
    output logic             s_vec,
    output logic [VEC_W-1:0] vector,
    output logic [N_IRQ-1:0] in_service,
    output logic [N_IRQ-1:0] mask
);

    localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    irq_state_e       state_q, state_d;
    logic [N_IRQ-1:0] irq_q;
    logic [N_IRQ-1:0] pending_q;
    logic [N_IRQ-1:0] in_service_q;
    logic [N_IRQ-1:0] mask_q;
    logic [IDX_W-1:0] id_q;

    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] blocked;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] entry_bit;
    logic [N_IRQ-1:0] reti_bit;
    logic             win_found, svc_found;
    logic [IDX_W-1:0] win_idx, svc_idx;
    logic             accept;

    assign rise     = irq & ~irq_q;
    assign eligible = pending_q & mask_q & ~blocked;
    assign accept   = (state_q == IDLE) && fetch && win_found;

    // entry_bit marks the line being vectored this cycle; reti_bit the
    // highest-priority active handler being retired.
    assign entry_bit = (state_q == JUMP) ? (N_IRQ'(1) << id_q) : '0;
    assign reti_bit  = (reti && svc_found) ? (N_IRQ'(1) << svc_idx) : '0;

    assign in_service = in_service_q;
    assign mask       = mask_q;

    irq_prio_enc #(.N_IRQ(N_IRQ), .IDX_W(IDX_W)) u_win_enc (
        .req   (eligible),
        .found (win_found),
        .idx   (win_idx)
    );

    irq_prio_enc #(.N_IRQ(N_IRQ), .IDX_W(IDX_W)) u_svc_enc (
        .req   (in_service_q),
        .found (svc_found),
        .idx   (svc_idx)
    );

    // Blocking: nested mode only lets lines above the active priority through.
    always_comb begin
        blocked = '0;
`ifdef NESTED_IRQ_EN
        for (int i = 0; i < N_IRQ; i++) begin
            if (svc_found && (i >= int'(svc_idx))) begin
                blocked[i] = 1'b1;
            end
        end
`else
        if (svc_found) begin
            blocked = '1;
        end
`endif
    end

    // Entry sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and entry strobes; the vector is only driven during JUMP.
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        push    = 1'b0;
        s_vec   = 1'b0;
        vector  = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PUSH;
                end
            end
            PUSH: begin
                take    = 1'b1;
                push    = 1'b1;
                state_d = JUMP;
            end
            JUMP: begin
                take    = 1'b1;
                s_vec   = 1'b1;
                vector  = VEC_BASE + VEC_W'(id_q) * VEC_W'(VEC_STRIDE);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Winner id is captured once at acceptance and held through the entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_q <= '0;
        end else if (accept) begin
            id_q <= win_idx;
        end
    end

    // Edge history, pending and in-service tracking; a new edge beats the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q        <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
        end else begin
            irq_q        <= irq;
            pending_q    <= (pending_q & ~entry_bit) | rise;
            in_service_q <= (in_service_q & ~reti_bit) | entry_bit;
        end
    end

    // Mask register written by the control unit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
        end else if (mask_we) begin
            mask_q <= mask_in;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq;
    logic       mask_we;
    logic [3:0] mask_in;
    logic       fetch;
    logic       reti;
    logic       take;
    logic       push;
    logic       s_vec;
    logic [9:0] vector;
    logic [3:0] in_service;
    logic [3:0] mask;

    int numVectors = 0;
    int numFails   = 0;

    // Reference model state
    logic [3:0] mPend, mSvc, mMask, mPrev;
    int         mId, mAcc, cyc;

    irq_ctrl #(
        .N_IRQ      (4),
        .VEC_W      (10),
        .VEC_BASE   (10'h3F0),
        .VEC_STRIDE (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .mask_we    (mask_we),
        .mask_in    (mask_in),
        .fetch      (fetch),
        .reti       (reti),
        .take       (take),
        .push       (push),
        .s_vec      (s_vec),
        .vector     (vector),
        .in_service (in_service),
        .mask       (mask)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic int lowestSet(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Highest-priority line that is pending, enabled and not held off by an
    // active handler; -1 when nothing may be taken.
    function automatic int winner(input logic [3:0] pend, input logic [3:0] msk,
                                  input logic [3:0] svc);
        int limit;
`ifdef NESTED_IRQ_EN
        limit = lowestSet(svc);
        if (limit < 0) limit = 4;
`else
        limit = (svc == 4'b0) ? 4 : 0;
`endif
        for (int i = 0; i < limit; i++) begin
            if (pend[i] && msk[i]) return i;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mPend = '0;
        mSvc  = '0;
        mMask = '0;
        mPrev = '0;
        mId   = 0;
        mAcc  = -100;
        cyc   = 0;
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic modelStep();
        logic       jumpNow, idleNow;
        logic [3:0] nPend, nSvc;
        int         w, ls;
        jumpNow = (cyc == mAcc + 2);
        idleNow = (cyc != mAcc + 1) && !jumpNow;
        w       = winner(mPend, mMask, mSvc);
        ls      = lowestSet(mSvc);
        nPend   = mPend;
        nSvc    = mSvc;
        if (jumpNow) begin
            nSvc[mId]  = 1'b1;
            nPend[mId] = 1'b0;
        end
        if (reti && ls >= 0) nSvc[ls] = 1'b0;
        nPend = nPend | (irq & ~mPrev);
        if (idleNow && fetch && w >= 0) begin
            mAcc = cyc;
            mId  = w;
        end
        if (mask_we) mMask = mask_in;
        mPrev = irq;
        mPend = nPend;
        mSvc  = nSvc;
        cyc++;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numVectors++;
        assert (got === exp) else begin
            numFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkOutput();
        logic        ePush, eVec;
        logic [31:0] eVector;
        ePush   = (cyc == mAcc + 1);
        eVec    = (cyc == mAcc + 2);
        eVector = eVec ? ((32'h3F0 + 32'(mId) * 32'd4) & 32'h3FF) : 32'h0;
        checkVal("take", 32'(take), 32'(ePush | eVec));
        checkVal("push", 32'(push), 32'(ePush));
        checkVal("s_vec", 32'(s_vec), 32'(eVec));
        checkVal("vector", 32'(vector), eVector);
        checkVal("in_service", 32'(in_service), 32'(mSvc));
        checkVal("mask", 32'(mask), 32'(mMask));
    endtask

    task automatic applyStimulus(input logic [3:0] i, input logic we, input logic [3:0] mi,
                                 input logic f, input logic r);
        irq     = i;
        mask_we = we;
        mask_in = mi;
        fetch   = f;
        reti    = r;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    initial begin
        logic [3:0] rIrq;
        reset   = 1'b1;
        irq     = '0;
        mask_we = 1'b0;
        mask_in = '0;
        fetch   = 1'b0;
        reti    = 1'b0;
        modelReset();
        #1;
        checkOutput();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        $display("[TB] reset released");

        // Basic entry on line 2 with fixed latency
        applyStimulus(4'b0000, 1'b1, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b0100, 1'b0, 4'h0, 1'b0, 1'b0);
        applyStimulus(4'b0100, 1'b0, 4'h0, 1'b0, 1'b0);
        applyStimulus(4'b0100, 1'b0, 4'h0, 1'b1, 1'b0);
        checkVal("s1_push", 32'(push), 32'd1);
        applyStimulus(4'b0100, 1'b0, 4'h0, 1'b0, 1'b0);
        checkVal("s1_vector", 32'(vector), 32'h3F8);
        applyStimulus(4'b0100, 1'b0, 4'h0, 1'b0, 1'b0);
        checkVal("s1_in_service", 32'(in_service), 32'b0100);
        applyStimulus(4'b0000, 1'b0, 4'h0, 1'b0, 1'b1);
        checkVal("s1_retired", 32'(in_service), 32'b0000);

        // Simultaneous lines 1 and 3: priority order
        applyStimulus(4'b1010, 1'b0, 4'h0, 1'b0, 1'b0);
        applyStimulus(4'b1010, 1'b0, 4'h0, 1'b1, 1'b0);
        applyStimulus(4'b1010, 1'b0, 4'h0, 1'b0, 1'b0);
        checkVal("s2_vector_a", 32'(vector), 32'h3F4);
        applyStimulus(4'b1010, 1'b0, 4'h0, 1'b0, 1'b0);
        applyStimulus(4'b1010, 1'b0, 4'h0, 1'b0, 1'b1);
        applyStimulus(4'b1010, 1'b0, 4'h0, 1'b1, 1'b0);
        applyStimulus(4'b1010, 1'b0, 4'h0, 1'b0, 1'b0);
        checkVal("s2_vector_b", 32'(vector), 32'h3FC);
        applyStimulus(4'b0000, 1'b0, 4'h0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 4'h0, 1'b0, 1'b1);

        // Masked line stays pending until enabled
        applyStimulus(4'b0000, 1'b1, 4'h0, 1'b0, 1'b0);
        applyStimulus(4'b0001, 1'b0, 4'h0, 1'b0, 1'b0);
        applyStimulus(4'b0001, 1'b0, 4'h0, 1'b1, 1'b0);
        checkVal("s3_masked_push", 32'(push), 32'd0);
        applyStimulus(4'b0001, 1'b1, 4'h1, 1'b0, 1'b0);
        applyStimulus(4'b0001, 1'b0, 4'h0, 1'b1, 1'b0);
        checkVal("s3_enabled_push", 32'(push), 32'd1);
        applyStimulus(4'b0001, 1'b0, 4'h0, 1'b0, 1'b0);
        checkVal("s3_vector", 32'(vector), 32'h3F0);
        applyStimulus(4'b0000, 1'b0, 4'h0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 4'h0, 1'b0, 1'b1);

        // Higher priority arriving while line 2 is active
        applyStimulus(4'b0000, 1'b1, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b0100, 1'b0, 4'h0, 1'b0, 1'b0);
        applyStimulus(4'b0100, 1'b0, 4'h0, 1'b1, 1'b0);
        applyStimulus(4'b0100, 1'b0, 4'h0, 1'b0, 1'b0);
        applyStimulus(4'b0100, 1'b0, 4'h0, 1'b0, 1'b0);
        applyStimulus(4'b0101, 1'b0, 4'h0, 1'b0, 1'b0);
        applyStimulus(4'b0101, 1'b0, 4'h0, 1'b1, 1'b0);
`ifdef NESTED_IRQ_EN
        checkVal("s4_push", 32'(push), 32'd1);
`else
        checkVal("s4_push", 32'(push), 32'd0);
`endif
        applyStimulus(4'b0101, 1'b0, 4'h0, 1'b0, 1'b0);
        applyStimulus(4'b0101, 1'b0, 4'h0, 1'b0, 1'b0);
`ifdef NESTED_IRQ_EN
        checkVal("s4_in_service", 32'(in_service), 32'b0101);
`else
        checkVal("s4_in_service", 32'(in_service), 32'b0100);
`endif
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b0000, 1'b0, 4'h0, 1'b1, 1'b0);
            applyStimulus(4'b0000, 1'b0, 4'h0, 1'b0, 1'b0);
            applyStimulus(4'b0000, 1'b0, 4'h0, 1'b0, 1'b0);
            applyStimulus(4'b0000, 1'b0, 4'h0, 1'b0, 1'b1);
        end
        checkVal("s4_drained", 32'(in_service), 32'b0000);

        // Re-rise of line 1 during its own JUMP cycle survives the clear
        applyStimulus(4'b0010, 1'b0, 4'h0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 4'h0, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b0, 4'h0, 1'b0, 1'b0);
        checkVal("s5_vector_a", 32'(vector), 32'h3F4);
        applyStimulus(4'b0010, 1'b0, 4'h0, 1'b0, 1'b0);
        checkVal("s5_in_service", 32'(in_service), 32'b0010);
        applyStimulus(4'b0010, 1'b0, 4'h0, 1'b0, 1'b1);
        applyStimulus(4'b0010, 1'b0, 4'h0, 1'b1, 1'b0);
        checkVal("s5_reentry_push", 32'(push), 32'd1);
        applyStimulus(4'b0010, 1'b0, 4'h0, 1'b0, 1'b0);
        checkVal("s5_vector_b", 32'(vector), 32'h3F4);
        applyStimulus(4'b0000, 1'b0, 4'h0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 4'h0, 1'b0, 1'b1);

        // Reset in the middle of an entry aborts it
        applyStimulus(4'b1000, 1'b0, 4'h0, 1'b0, 1'b0);
        applyStimulus(4'b1000, 1'b0, 4'h0, 1'b1, 1'b0);
        checkVal("s6_push_before", 32'(push), 32'd1);
        irq   = 4'b0000;
        fetch = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput();
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(4'b0000, 1'b0, 4'h0, 1'b0, 1'b0);
        checkVal("s6_push_after", 32'(push), 32'd0);
        checkVal("s6_svec_after", 32'(s_vec), 32'd0);
        checkVal("s6_in_service", 32'(in_service), 32'd0);
        applyStimulus(4'b0000, 1'b1, 4'hF, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 4'h0, 1'b1, 1'b0);
        checkVal("s6_no_pending", 32'(push), 32'd0);
        applyStimulus(4'b0000, 1'b0, 4'h0, 1'b0, 1'b0);

        // Random traffic against the model
        rIrq = 4'b0000;
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 3) == 0) rIrq = 4'($urandom_range(0, 15));
            applyStimulus(rIrq,
                          1'($urandom_range(0, 7) == 0),
                          4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 2) == 0),
                          1'($urandom_range(0, 5) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numFails);
        $finish;
    end

endmodule
